// File: rtl/mem_bus_pkg.sv
// Shared definitions for the word-register memory port: op codes, register map,
// initiator state encoding and strobe idle level.
package mem_bus_pkg;
  localparam int DATA_W = 32;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned NREG = 3;

  localparam logic STROBE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_RAW = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_DONE
  } state_e;
endpackage

// File: rtl/mem_dir_check.sv
// Combinational address-valid decode for the register window; shared by the
// initiator and the responder so both sides agree on what is addressable.
module mem_dir_check
  import mem_bus_pkg::*;
(
  input  logic [31:0] addr,
  output logic        ok
);
  logic [31:0] off;
  logic [31:0] idx;

  always_comb begin
    off = addr - BASE;
    idx = off >> 2;
    // Unsigned wrap makes addresses below BASE land far above NREG.
    ok  = (addr[1:0] == 2'b00) && (idx < NREG);
  end
endmodule

// File: rtl/mem_initiator.sv
// Single-command bus initiator: read, write and read-add-write toward the
// memory responder with active-low strobes; bad addresses fail locally.
module mem_initiator
  import mem_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              Mem_rd,
  output logic              Mem_wr,
  output logic [31:0]       Dir_Mem,
  output logic [DATA_W-1:0] Dato_Mem_out,
  input  logic [DATA_W-1:0] Dato_Mem_in
);
  state_e            state;
  state_e            state_nxt;
  op_e               op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       dir_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              addr_ok;
  logic              bad_cmd;

  mem_dir_check u_dir_check (
    .addr (addr),
    .ok   (addr_ok)
  );

  assign bad_cmd = !addr_ok || (op == OP_RSV);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (bad_cmd)           state_nxt = S_DONE;
          else if (op == OP_WR)  state_nxt = S_WR;
          else                   state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = S_RWAIT;
      S_RWAIT: state_nxt = (op_q == OP_RAW) ? S_WR : S_DONE;
      S_WR:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state and data, never on inputs.
  always_comb begin
    Mem_rd       = (state == S_RD) ? ~STROBE_IDLE : STROBE_IDLE;
    Mem_wr       = (state == S_WR) ? ~STROBE_IDLE : STROBE_IDLE;
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    err          = err_q;
    rdata        = rdata_q;
    Dir_Mem      = dir_q;
    Dato_Mem_out = dout_q;
  end

  // Command capture and read/modify datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_RD;
      wdata_q <= '0;
      dir_q   <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            wdata_q <= wdata;
            dir_q   <= addr;
            err_q   <= bad_cmd;
            if (!bad_cmd && (op == OP_WR)) dout_q <= wdata;
          end
        end
        S_RWAIT: begin
          rdata_q <= Dato_Mem_in;
          if (op_q == OP_RAW) dout_q <= Dato_Mem_in + wdata_q;
        end
        default: ;
      endcase
    end
  end
endmodule
